// File: rtl/mrnaiso_sequencer.sv
// mrnaiso_sequencer: valve sequencer for a bank of SIZE mRNA-isolation lanes.
// Runs LOAD, BEADS, LYSIS, MIX (peristaltic pump), SEP, PUSH, FLUSH, DONE.
// Each output register is loaded from the decode of the next state, so a
// state's valve pattern appears on the same edge as the state change.
module mrnaiso_sequencer #(
    parameter int SIZE = 2,
    parameter int DW   = 8,
    parameter int SW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] lane_mask,
    input  logic [DW-1:0]   dwell_len,
    input  logic [DW-1:0]   phase_len,
    input  logic [SW-1:0]   strokes,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] cells_in_ctrl,
    output logic [SIZE-1:0] waste_ctrl,
    output logic [SIZE-1:0] collect_ctrl,
    output logic            cells_out_ctrl,
    output logic            beads_ctrl,
    output logic            sieve_ctrl,
    output logic            lysis_in_ctrl,
    output logic            lysis_out_ctrl,
    output logic            sep_ctrl,
    output logic            push_ctrl,
    output logic [2:0]      pump,
    output logic [12:0]     flush
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_BEADS = 4'd2;
    localparam logic [3:0] S_LYSIS = 4'd3;
    localparam logic [3:0] S_MIX   = 4'd4;
    localparam logic [3:0] S_SEP   = 4'd5;
    localparam logic [3:0] S_PUSH  = 4'd6;
    localparam logic [3:0] S_FLUSH = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [DW-1:0] ONE_DW = DW'(1);
    localparam logic [SW-1:0] ONE_SW = SW'(1);

    logic [3:0]      state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ph_q, ph_d;
    logic [SW-1:0]   stk_q, stk_d;
    logic [SIZE-1:0] mask_q, mask_d;
    logic [DW-1:0]   dlen_q, dlen_d;
    logic [DW-1:0]   plen_q, plen_d;
    logic [SW-1:0]   str_q, str_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SIZE-1:0] cells_in_q, cells_in_d;
    logic [SIZE-1:0] waste_q, waste_d;
    logic [SIZE-1:0] collect_q, collect_d;
    logic            cells_out_q, cells_out_d;
    logic            beads_q, beads_d;
    logic            sieve_q, sieve_d;
    logic            lysis_in_q, lysis_in_d;
    logic            lysis_out_q, lysis_out_d;
    logic            sep_q, sep_d;
    logic            push_q, push_d;
    logic [2:0]      pump_q, pump_d;
    logic [12:0]     flush_q, flush_d;

    logic [DW-1:0]   dwell_ld, phase_ld;

    // Zero dwell/phase lengths are promoted to one cycle before latching.
    always_comb begin
        dwell_ld = (dwell_len == '0) ? ONE_DW : dwell_len;
        phase_ld = (phase_len == '0) ? ONE_DW : phase_len;
    end

    // Next-state, counter and parameter-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        stk_d   = stk_q;
        mask_d  = mask_q;
        dlen_d  = dlen_q;
        plen_d  = plen_q;
        str_d   = str_q;
        case (state_q)
            S_IDLE: begin
                if (start && (lane_mask != '0)) begin
                    state_d = S_LOAD;
                    mask_d  = lane_mask;
                    dlen_d  = dwell_ld;
                    plen_d  = phase_ld;
                    str_d   = strokes;
                    cnt_d   = dwell_ld - ONE_DW;
                end
            end
            S_LOAD, S_BEADS, S_LYSIS, S_MIX, S_SEP, S_PUSH: begin
                if (abort) begin
                    state_d = S_FLUSH;
                    cnt_d   = dlen_q - ONE_DW;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_DW;
                end else begin
                    cnt_d = dlen_q - ONE_DW;
                    case (state_q)
                        S_LOAD:  state_d = S_BEADS;
                        S_BEADS: state_d = S_LYSIS;
                        S_LYSIS: begin
                            if (str_q == '0) begin
                                state_d = S_SEP;
                            end else begin
                                state_d = S_MIX;
                                cnt_d   = plen_q - ONE_DW;
                                ph_d    = 3'd0;
                                stk_d   = '0;
                            end
                        end
                        S_MIX: begin
                            if (ph_q != 3'd5) begin
                                ph_d  = ph_q + 3'd1;
                                cnt_d = plen_q - ONE_DW;
                            end else if (stk_q == str_q - ONE_SW) begin
                                state_d = S_SEP;
                            end else begin
                                ph_d  = 3'd0;
                                stk_d = stk_q + ONE_SW;
                                cnt_d = plen_q - ONE_DW;
                            end
                        end
                        S_SEP:   state_d = S_PUSH;
                        default: state_d = S_FLUSH;
                    endcase
                end
            end
            S_FLUSH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_DW;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so outputs are registered with no lag.
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cells_in_d  = '1;
        waste_d     = '1;
        collect_d   = '1;
        cells_out_d = 1'b1;
        beads_d     = 1'b1;
        sieve_d     = 1'b1;
        lysis_in_d  = 1'b1;
        lysis_out_d = 1'b1;
        sep_d       = 1'b1;
        push_d      = 1'b1;
        pump_d      = 3'b111;
        flush_d     = '0;
        case (state_d)
            S_LOAD: begin
                busy_d      = 1'b1;
                cells_in_d  = ~mask_d;
                cells_out_d = 1'b0;
            end
            S_BEADS: begin
                busy_d  = 1'b1;
                beads_d = 1'b0;
                sieve_d = 1'b0;
            end
            S_LYSIS: begin
                busy_d      = 1'b1;
                lysis_in_d  = 1'b0;
                lysis_out_d = 1'b0;
            end
            S_MIX: begin
                busy_d = 1'b1;
                case (ph_d)
                    3'd0:    pump_d = 3'b110;
                    3'd1:    pump_d = 3'b100;
                    3'd2:    pump_d = 3'b101;
                    3'd3:    pump_d = 3'b001;
                    3'd4:    pump_d = 3'b011;
                    default: pump_d = 3'b010;
                endcase
            end
            S_SEP: begin
                busy_d  = 1'b1;
                sep_d   = 1'b0;
                waste_d = ~mask_d;
            end
            S_PUSH: begin
                busy_d    = 1'b1;
                push_d    = 1'b0;
                collect_d = ~mask_d;
            end
            S_FLUSH: begin
                busy_d  = 1'b1;
                flush_d = '1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ph_q        <= '0;
            stk_q       <= '0;
            mask_q      <= '0;
            dlen_q      <= ONE_DW;
            plen_q      <= ONE_DW;
            str_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cells_in_q  <= '1;
            waste_q     <= '1;
            collect_q   <= '1;
            cells_out_q <= 1'b1;
            beads_q     <= 1'b1;
            sieve_q     <= 1'b1;
            lysis_in_q  <= 1'b1;
            lysis_out_q <= 1'b1;
            sep_q       <= 1'b1;
            push_q      <= 1'b1;
            pump_q      <= 3'b111;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            stk_q       <= stk_d;
            mask_q      <= mask_d;
            dlen_q      <= dlen_d;
            plen_q      <= plen_d;
            str_q       <= str_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cells_in_q  <= cells_in_d;
            waste_q     <= waste_d;
            collect_q   <= collect_d;
            cells_out_q <= cells_out_d;
            beads_q     <= beads_d;
            sieve_q     <= sieve_d;
            lysis_in_q  <= lysis_in_d;
            lysis_out_q <= lysis_out_d;
            sep_q       <= sep_d;
            push_q      <= push_d;
            pump_q      <= pump_d;
            flush_q     <= flush_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign cells_in_ctrl  = cells_in_q;
    assign waste_ctrl     = waste_q;
    assign collect_ctrl   = collect_q;
    assign cells_out_ctrl = cells_out_q;
    assign beads_ctrl     = beads_q;
    assign sieve_ctrl     = sieve_q;
    assign lysis_in_ctrl  = lysis_in_q;
    assign lysis_out_ctrl = lysis_out_q;
    assign sep_ctrl       = sep_q;
    assign push_ctrl      = push_q;
    assign pump           = pump_q;
    assign flush          = flush_q;

endmodule

// File: tb/tb_mrnaiso_sequencer.sv
// Scoreboard bench for mrnaiso_sequencer: each run pushes its expected
// per-cycle output vectors, which are popped and compared cycle by cycle.
module tb_mrnaiso_sequencer;

    typedef logic [30:0] vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] lane_mask = '0;
    logic [7:0] dwell_len = '0;
    logic [7:0] phase_len = '0;
    logic [7:0] strokes = '0;
    logic       busy, done;
    logic [1:0] cells_in_ctrl, waste_ctrl, collect_ctrl;
    logic       cells_out_ctrl, beads_ctrl, sieve_ctrl, lysis_in_ctrl;
    logic       lysis_out_ctrl, sep_ctrl, push_ctrl;
    logic [2:0] pump;
    logic [12:0] flush;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t exp_q[$];

    mrnaiso_sequencer #(.SIZE(2), .DW(8), .SW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lane_mask(lane_mask), .dwell_len(dwell_len), .phase_len(phase_len),
        .strokes(strokes), .busy(busy), .done(done),
        .cells_in_ctrl(cells_in_ctrl), .waste_ctrl(waste_ctrl),
        .collect_ctrl(collect_ctrl), .cells_out_ctrl(cells_out_ctrl),
        .beads_ctrl(beads_ctrl), .sieve_ctrl(sieve_ctrl),
        .lysis_in_ctrl(lysis_in_ctrl), .lysis_out_ctrl(lysis_out_ctrl),
        .sep_ctrl(sep_ctrl), .push_ctrl(push_ctrl), .pump(pump), .flush(flush)
    );

    always #5 clk = ~clk;

    // Step codes: 0 idle,1 load,2 beads,3 lysis,4 mix,5 sep,6 push,7 flush,8 done
    function automatic vec_t mk(input int st, input int ph, input logic [1:0] m);
        logic       b, d;
        logic [1:0] ci, wa, co;
        logic [2:0] pp;
        logic [12:0] fl;
        b  = (st >= 1 && st <= 7);
        d  = (st == 8);
        ci = (st == 1) ? ~m : 2'b11;
        wa = (st == 5) ? ~m : 2'b11;
        co = (st == 6) ? ~m : 2'b11;
        fl = (st == 7) ? 13'h1fff : 13'h0000;
        pp = 3'b111;
        if (st == 4) begin
            case (ph)
                0: pp = 3'b110;
                1: pp = 3'b100;
                2: pp = 3'b101;
                3: pp = 3'b001;
                4: pp = 3'b011;
                default: pp = 3'b010;
            endcase
        end
        return {b, d, ci, wa, co, (st != 1), (st != 2), (st != 2), (st != 3),
                (st != 3), (st != 5), (st != 6), pp, fl};
    endfunction

    function automatic vec_t observed();
        return {busy, done, cells_in_ctrl, waste_ctrl, collect_ctrl,
                cells_out_ctrl, beads_ctrl, sieve_ctrl, lysis_in_ctrl,
                lysis_out_ctrl, sep_ctrl, push_ctrl, pump, flush};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One run: build the expected trace, drive start, compare every cycle.
    task automatic run(input string tag, input logic [1:0] m, input logic [7:0] dl,
                       input logic [7:0] pl, input logic [7:0] s, input int ab_cyc,
                       input int rst_cyc, input bit ab_at_start, input bit st_in_flush);
        vec_t full[$];
        int   dd, pp, n;
        dd = (dl == 0) ? 1 : int'(dl);
        pp = (pl == 0) ? 1 : int'(pl);
        if (m == 2'b00) begin
            for (int i = 0; i < 3; i++) full.push_back(mk(0, 0, m));
        end else begin
            for (int st = 1; st <= 3; st++)
                for (int i = 0; i < dd; i++) full.push_back(mk(st, 0, m));
            for (int k = 0; k < int'(s); k++)
                for (int ph = 0; ph < 6; ph++)
                    for (int i = 0; i < pp; i++) full.push_back(mk(4, ph, m));
            for (int st = 5; st <= 7; st++)
                for (int i = 0; i < dd; i++) full.push_back(mk(st, 0, m));
            full.push_back(mk(8, 0, m));
            full.push_back(mk(0, 0, m));
        end
        if (ab_cyc > 0) begin
            for (int i = 0; i < ab_cyc; i++) exp_q.push_back(full[i]);
            for (int i = 0; i < dd; i++) exp_q.push_back(mk(7, 0, m));
            exp_q.push_back(mk(8, 0, m));
            exp_q.push_back(mk(0, 0, m));
        end else if (rst_cyc > 0) begin
            for (int i = 0; i < rst_cyc; i++) exp_q.push_back(full[i]);
            exp_q.push_back(mk(0, 0, m));
            exp_q.push_back(mk(0, 0, m));
        end else begin
            foreach (full[i]) exp_q.push_back(full[i]);
        end
        @(negedge clk);
        lane_mask = m; dwell_len = dl; phase_len = pl; strokes = s;
        start = 1'b1; abort = ab_at_start;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            check_eq($sformatf("%s_c%0d", tag, n), 64'(observed()), 64'(exp_q.pop_front()));
            abort = (n == ab_cyc);
            rst   = (n == rst_cyc);
            if (st_in_flush && n == ab_cyc + 1) begin
                start = 1'b1; lane_mask = 2'b11;
            end
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset", 64'(observed()), 64'(mk(0, 0, 2'b00)));
        rst = 1'b0;
        run("basic",      2'b11, 8'd3, 8'd1, 8'd2, 0, 0, 1'b0, 1'b0);
        run("mask01",     2'b01, 8'd2, 8'd2, 8'd1, 0, 0, 1'b0, 1'b0);
        run("zerodwell",  2'b11, 8'd0, 8'd1, 8'd0, 0, 0, 1'b0, 1'b0);
        run("abort",      2'b11, 8'd3, 8'd1, 8'd2, 11, 0, 1'b0, 1'b1);
        run("rst_sep",    2'b11, 8'd2, 8'd1, 8'd1, 0, 13, 1'b0, 1'b0);
        run("zeromask",   2'b00, 8'd2, 8'd1, 8'd1, 0, 0, 1'b0, 1'b0);
        run("startabort", 2'b10, 8'd1, 8'd3, 8'd1, 0, 0, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
